// File: rtl/frame_buf_pingpong.sv
// Ping-pong pixel frame store: the writer fills the back bank while the reader scans the front
// bank; banks swap only at a frame boundary. FB_BLANK_FIRST_FRAME_EN blanks reads until 1st swap.
module frame_buf_pingpong #(
  parameter int unsigned CH_W   = 8,
  parameter int unsigned NUM_CH = 3,
  parameter int unsigned DEPTH  = 10000,
  parameter int unsigned ADDR_W = 20
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [NUM_CH*CH_W-1:0]   wr_data,
  input  logic                     wr_frame_done,
  output logic                     wr_ready,
  input  logic                     rd_en,
  input  logic [ADDR_W-1:0]        rd_addr,
  input  logic                     rd_frame_done,
  output logic [NUM_CH*CH_W-1:0]   rd_data,
  output logic                     rd_valid,
  output logic                     front_sel,
  output logic                     swap_pulse,
  output logic                     oor_err
);
  localparam int unsigned PIX_W = NUM_CH * CH_W;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DepthA = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [0:0] {StFill, StWaitSwap} state_e;

  logic [PIX_W-1:0] bank0_mem [DEPTH];
  logic [PIX_W-1:0] bank1_mem [DEPTH];

  state_e           state_q, state_d;
  logic             front_sel_q, front_sel_d;
  logic             wr_ready_q, wr_ready_d;
  logic             swap_pulse_q, swap_pulse_d;
  logic             oor_err_q, oor_err_d;
  logic             rd_valid_q, rd_valid_d;
  logic [PIX_W-1:0] rd_data_q, rd_data_d;
  logic             wr_in_range, rd_in_range, swap, wr_fire, blank;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic [PIX_W-1:0] rd_word;

`ifdef FB_BLANK_FIRST_FRAME_EN
  logic blank_q, blank_d;
  assign blank   = blank_q;
  assign blank_d = blank_q & ~swap;

  always_ff @(posedge clk) begin
    if (reset) blank_q <= 1'b1;
    else       blank_q <= blank_d;
  end
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    wr_in_range  = {1'b0, wr_addr} < DepthA;
    rd_in_range  = {1'b0, rd_addr} < DepthA;
    wr_idx       = wr_addr[IDX_W-1:0];
    rd_idx       = rd_addr[IDX_W-1:0];
    // Same-cycle wr/rd frame-done in FILL swaps at once; in WAIT_SWAP the reader alone decides.
    swap         = rd_frame_done && (state_q == StWaitSwap || wr_frame_done);
    wr_fire      = wr_en && wr_ready_q && wr_in_range;
    rd_word      = front_sel_q ? bank1_mem[rd_idx] : bank0_mem[rd_idx];

    state_d = state_q;
    unique case (state_q)
      StFill:     if (wr_frame_done && !rd_frame_done) state_d = StWaitSwap;
      StWaitSwap: if (rd_frame_done) state_d = StFill;
    endcase

    front_sel_d  = front_sel_q ^ swap;
    wr_ready_d   = (state_d == StFill);
    swap_pulse_d = swap;
    oor_err_d    = oor_err_q | (wr_en & ~wr_in_range) | (rd_en & ~rd_in_range);
    rd_valid_d   = rd_en;
    rd_data_d    = rd_data_q;
    if (rd_en) rd_data_d = (rd_in_range && !blank) ? rd_word : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StFill;
      front_sel_q  <= 1'b0;
      wr_ready_q   <= 1'b1;
      swap_pulse_q <= 1'b0;
      oor_err_q    <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      front_sel_q  <= front_sel_d;
      wr_ready_q   <= wr_ready_d;
      swap_pulse_q <= swap_pulse_d;
      oor_err_q    <= oor_err_d;
      rd_valid_q   <= rd_valid_d;
      rd_data_q    <= rd_data_d;
    end
  end

  // Memory is never cleared; writes always target the bank that is not being scanned out.
  always_ff @(posedge clk) begin
    if (wr_fire && !reset) begin
      if (front_sel_q) bank0_mem[wr_idx] <= wr_data;
      else             bank1_mem[wr_idx] <= wr_data;
    end
  end

  assign wr_ready   = wr_ready_q;
  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign front_sel  = front_sel_q;
  assign swap_pulse = swap_pulse_q;
  assign oor_err    = oor_err_q;

endmodule

// File: tb/tb_frame_buf_pingpong.sv
// Bench for frame_buf_pingpong: directed steps then random traffic, each cycle checked against
// a bank/frame model built from the ping-pong swap rules.
module tb_frame_buf_pingpong;
  localparam int DEPTH = 10000;
`ifdef FB_BLANK_FIRST_FRAME_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset, wr_en, wr_frame_done, rd_en, rd_frame_done;
  logic [19:0] wr_addr, rd_addr;
  logic [23:0] wr_data, rd_data;
  logic        wr_ready, rd_valid, front_sel, swap_pulse, oor_err;

  frame_buf_pingpong dut (
    .clk           (clk),
    .reset         (reset),
    .wr_en         (wr_en),
    .wr_addr       (wr_addr),
    .wr_data       (wr_data),
    .wr_frame_done (wr_frame_done),
    .wr_ready      (wr_ready),
    .rd_en         (rd_en),
    .rd_addr       (rd_addr),
    .rd_frame_done (rd_frame_done),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .front_sel     (front_sel),
    .swap_pulse    (swap_pulse),
    .oor_err       (oor_err)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Model: two banks of pixels with "written" flags (unwritten contents are unknown).
  logic [23:0] mem   [2][DEPTH];
  bit          known [2][DEPTH];
  bit          m_front, m_wait, m_valid, m_known, m_pulse, m_oor, m_unswapped;
  logic [23:0] m_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit rst, input bit we, input int wa, input logic [23:0] wd,
                      input bit wfd, input bit re, input int ra, input bit rfd);
    bit swap;
    reset = rst; wr_en = we; wr_addr = 20'(wa); wr_data = wd; wr_frame_done = wfd;
    rd_en = re; rd_addr = 20'(ra); rd_frame_done = rfd;
    @(posedge clk);
    if (rst) begin
      m_front = 0; m_wait = 0; m_valid = 0; m_data = '0; m_known = 1;
      m_pulse = 0; m_oor = 0; m_unswapped = 1;
    end else begin
      swap = rfd && (m_wait || wfd);
      m_valid = re;
      if (re) begin
        if (ra >= DEPTH) begin
          m_data = '0; m_known = 1; m_oor = 1;
        end else if (BLANK && m_unswapped) begin
          m_data = '0; m_known = 1;
        end else begin
          m_data = mem[m_front][ra]; m_known = known[m_front][ra];
        end
      end
      if (we && wa >= DEPTH) m_oor = 1;
      if (we && !m_wait && wa < DEPTH) begin
        mem[!m_front][wa] = wd;
        known[!m_front][wa] = 1;
      end
      if (swap) begin
        m_front = !m_front; m_wait = 0; m_unswapped = 0;
      end else if (wfd) begin
        m_wait = 1;
      end
      m_pulse = swap;
    end
    #1;
    check("front_sel", 32'(front_sel), 32'(m_front));
    check("wr_ready", 32'(wr_ready), 32'(!m_wait));
    check("rd_valid", 32'(rd_valid), 32'(m_valid));
    check("swap_pulse", 32'(swap_pulse), 32'(m_pulse));
    check("oor_err", 32'(oor_err), 32'(m_oor));
    if (m_known) check("rd_data", 32'(rd_data), 32'(m_data));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, '0, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset and first read.
    step(1, 0, 0, '0, 0, 0, 0, 0);
    step(1, 0, 0, '0, 0, 0, 0, 0);
    check("reset_rd_data", 32'(rd_data), 32'h0);
    step(0, 0, 0, '0, 0, 1, 0, 0);
    if (BLANK) check("blank_read0", 32'(rd_data), 32'h0);

    // Write into back bank 1, wait for vsync, swap, read back.
    step(0, 1, 5, 24'h112233, 0, 0, 0, 0);
    step(0, 0, 0, '0, 1, 0, 0, 0);
    check("wait_swap_ready", 32'(wr_ready), 32'h0);
    idle(3);
    step(0, 0, 0, '0, 0, 0, 0, 1);
    check("swap_pulse_hi", 32'(swap_pulse), 32'h1);
    check("front_after_swap", 32'(front_sel), 32'h1);
    step(0, 0, 0, '0, 0, 1, 5, 0);
    check("swap_pulse_once", 32'(swap_pulse), 32'h0);
    check("pix5", 32'(rd_data), 32'h112233);
    check("pix5_R", 32'(rd_data[7:0]), 32'h33);
    check("pix5_G", 32'(rd_data[15:8]), 32'h22);
    check("pix5_B", 32'(rd_data[23:16]), 32'h11);

    // Write dropped while waiting for swap.
    step(0, 1, 6, 24'h445566, 0, 0, 0, 0);
    step(0, 0, 0, '0, 1, 0, 0, 0);
    step(0, 1, 6, 24'hAAAAAA, 0, 0, 0, 0);
    step(0, 0, 0, '0, 0, 0, 0, 1);
    step(0, 0, 0, '0, 0, 1, 6, 0);
    check("dropped_write", 32'(rd_data), 32'h445566);

    // Simultaneous frame-done: immediate swap, read in that cycle sees the old front.
    step(0, 1, 7, 24'h0F0F0F, 0, 0, 0, 0);
    step(0, 0, 0, '0, 1, 1, 6, 1);
    check("simul_old_bank", 32'(rd_data), 32'h445566);
    check("simul_ready", 32'(wr_ready), 32'h1);
    check("simul_front", 32'(front_sel), 32'h1);
    step(0, 0, 0, '0, 0, 1, 7, 0);
    check("simul_new_bank", 32'(rd_data), 32'h0F0F0F);

    // Out-of-range accesses.
    step(0, 1, 10000, 24'hFFFFFF, 0, 1, 12000, 0);
    check("oor_rd_data", 32'(rd_data), 32'h0);
    check("oor_rd_valid", 32'(rd_valid), 32'h1);
    idle(4);
    check("oor_sticky", 32'(oor_err), 32'h1);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      int wa, ra;
      wa = ($urandom_range(0, 19) == 0) ? 10000 + int'($urandom_range(0, 50))
                                        : int'($urandom_range(0, 15));
      ra = ($urandom_range(0, 19) == 0) ? 9990 + int'($urandom_range(0, 40))
                                        : int'($urandom_range(0, 15));
      step($urandom_range(0, 99) == 0, 1'($urandom_range(0, 1)), wa, 24'($urandom),
           $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)), ra, $urandom_range(0, 5) == 0);
    end

    // Reset while waiting for swap loses the pending swap.
    idle(1);
    step(0, 0, 0, '0, 1, 0, 0, 0);
    step(1, 0, 0, '0, 0, 0, 0, 0);
    check("rst_wait_front", 32'(front_sel), 32'h0);
    check("rst_wait_ready", 32'(wr_ready), 32'h1);
    step(0, 0, 0, '0, 0, 0, 0, 1);
    check("rst_wait_nopulse", 32'(swap_pulse), 32'h0);
    check("rst_wait_oor", 32'(oor_err), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
